// File: rtl/countdown_sequencer_if.sv
// Control/status bundle between the push-button front end, the one-second
// timer and the display decoders for the BCD countdown sequencer.
interface countdown_sequencer_if;
    logic       load_i;
    logic [7:0] preset_i;
    logic       start_i;
    logic       pause_i;
    logic       tick_i;
    logic       timer_rst_n_o;
    logic       timer_start_o;
    logic [3:0] tens_o;
    logic [3:0] ones_o;
    logic       busy_o;
    logic       done_o;
    logic       timeout_o;

    modport slave (
        input  load_i, preset_i, start_i, pause_i, tick_i,
        output timer_rst_n_o, timer_start_o, tens_o, ones_o, busy_o, done_o, timeout_o
    );

    modport master (
        output load_i, preset_i, start_i, pause_i, tick_i,
        input  timer_rst_n_o, timer_start_o, tens_o, ones_o, busy_o, done_o, timeout_o
    );
endinterface

// File: rtl/countdown_sequencer.sv
// Two-digit BCD seconds countdown: sequences the one-second timer (reset/start)
// and decrements the count on each timer tick; all outputs registered.
module countdown_sequencer #(
    parameter logic [7:0] DEFAULT_PRESET = 8'h30
) (
    input  logic           clk,
    input  logic           rst,
    countdown_sequencer_if.slave cs
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] tens_q, ones_q, tens_d, ones_d;
    logic [7:0] reload_q, reload_d;
    logic [3:0] clamp_tens, clamp_ones;
    logic       cnt_zero, cnt_one;

    logic       timer_rst_n_q, timer_start_q, busy_q, done_q, timeout_q;
    logic       timer_rst_n_d, timer_start_d, busy_d, done_d, timeout_d;

    assign clamp_tens = (cs.preset_i[7:4] > 4'd9) ? 4'd9 : cs.preset_i[7:4];
    assign clamp_ones = (cs.preset_i[3:0] > 4'd9) ? 4'd9 : cs.preset_i[3:0];
    assign cnt_zero   = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign cnt_one    = (tens_q == 4'd0) && (ones_q == 4'd1);

    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        reload_d = reload_q;

        // load wins over everything, but a running count cannot be disturbed
        if (cs.load_i && state_q != RUN) begin
            tens_d   = clamp_tens;
            ones_d   = clamp_ones;
            reload_d = {clamp_tens, clamp_ones};
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs.start_i && !cnt_zero) state_d = RUN;
                end
                RUN: begin
                    if (cs.tick_i && !cnt_zero) begin
                        if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                    end
                    // reaching 00 beats a coincident pause
                    if (cs.tick_i && cnt_one) state_d = DONE;
                    else if (cs.pause_i)      state_d = PAUSE;
                end
                PAUSE: begin
                    if (cs.start_i) state_d = RUN;
                end
                DONE: begin
                    if (cs.start_i) begin
                        tens_d = reload_q[7:4];
                        ones_d = reload_q[3:0];
                        if (reload_q != 8'h00) state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs reflect the state being entered so they are valid with it.
    always_comb begin
        timer_rst_n_d = (state_d == RUN);
        timer_start_d = (state_d == RUN) && (state_q != RUN);
        busy_d        = (state_d == RUN) || (state_d == PAUSE);
        done_d        = (state_d == DONE) && (state_q == RUN);
        timeout_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            tens_q        <= DEFAULT_PRESET[7:4];
            ones_q        <= DEFAULT_PRESET[3:0];
            reload_q      <= DEFAULT_PRESET;
            timer_rst_n_q <= 1'b0;
            timer_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            reload_q      <= reload_d;
            timer_rst_n_q <= timer_rst_n_d;
            timer_start_q <= timer_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    assign cs.tens_o        = tens_q;
    assign cs.ones_o        = ones_q;
    assign cs.timer_rst_n_o = timer_rst_n_q;
    assign cs.timer_start_o = timer_start_q;
    assign cs.busy_o        = busy_q;
    assign cs.done_o        = done_q;
    assign cs.timeout_o     = timeout_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer: expected output snapshots are queued
// as each step is driven and checked when the cycle's outputs settle.
module tb_countdown_sequencer;

    logic clk;
    logic rst;

    countdown_sequencer_if ifc ();

    countdown_sequencer #(.DEFAULT_PRESET(8'h30)) dut (
        .clk (clk),
        .rst (rst),
        .cs  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // {tens, ones, busy, done, timeout, timer_rst_n, timer_start}
    function automatic logic [12:0] e(int n, logic b, logic d, logic t, logic r, logic s);
        return {4'(n / 10), 4'(n % 10), b, d, t, r, s};
    endfunction

    function automatic logic [12:0] f_idle(int n);  return e(n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endfunction
    function automatic logic [12:0] f_start(int n); return e(n, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); endfunction
    function automatic logic [12:0] f_run(int n);   return e(n, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); endfunction
    function automatic logic [12:0] f_pause(int n); return e(n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endfunction
    function automatic logic [12:0] f_done1();      return e(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); endfunction
    function automatic logic [12:0] f_done();       return e(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endfunction

    task automatic compare_front();
        exp_t        x;
        logic [12:0] obs;
        x   = sb.pop_front();
        obs = {ifc.tens_o, ifc.ones_o, ifc.busy_o, ifc.done_o, ifc.timeout_o,
               ifc.timer_rst_n_o, ifc.timer_start_o};
        n_cmp++;
        assert (obs === x.v) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
        end
    endtask

    task automatic cyc(input string tag, input logic ld, input logic st, input logic ps,
                       input logic tk, input logic [12:0] ev);
        ifc.load_i  = ld;
        ifc.start_i = st;
        ifc.pause_i = ps;
        ifc.tick_i  = tk;
        sb.push_back('{tag, ev});
        @(posedge clk);
        @(negedge clk);
        compare_front();
        ifc.load_i  = 1'b0;
        ifc.start_i = 1'b0;
        ifc.pause_i = 1'b0;
        ifc.tick_i  = 1'b0;
    endtask

    task automatic check_now(input string tag, input logic [12:0] ev);
        sb.push_back('{tag, ev});
        compare_front();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ifc.load_i   = 1'b0;
        ifc.start_i  = 1'b0;
        ifc.pause_i  = 1'b0;
        ifc.tick_i   = 1'b0;
        ifc.preset_i = 8'h00;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_now("reset_now", f_idle(30));
        repeat (3) cyc("reset_hold", 1'b0, 1'b1, 1'b0, 1'b1, f_idle(30));
        rst = 1'b1;
        repeat (5) cyc("idle_tick", 1'b0, 1'b0, 1'b0, 1'b1, f_idle(30));

        // 12 -> 00 with ticks 24 cycles apart
        ifc.preset_i = 8'h12;
        cyc("load12", 1'b1, 1'b0, 1'b0, 1'b0, f_idle(12));
        cyc("start12", 1'b0, 1'b1, 1'b0, 1'b0, f_start(12));
        n = 12;
        for (int k = 1; k <= 12; k++) begin
            repeat (23) cyc("run12_gap", 1'b0, 1'b0, 1'b0, 1'b0, f_run(n));
            n--;
            cyc("run12_tick", 1'b0, 1'b0, 1'b0, 1'b1, (n == 0) ? f_done1() : f_run(n));
        end
        cyc("done12_hold", 1'b0, 1'b0, 1'b0, 1'b1, f_done());

        // borrow, pause with coincident tick, resume
        ifc.preset_i = 8'h10;
        cyc("load10", 1'b1, 1'b0, 1'b0, 1'b0, f_idle(10));
        cyc("start10", 1'b0, 1'b1, 1'b0, 1'b0, f_start(10));
        repeat (3) cyc("run10_gap", 1'b0, 1'b0, 1'b0, 1'b0, f_run(10));
        cyc("borrow", 1'b0, 1'b0, 1'b0, 1'b1, f_run(9));
        repeat (3) cyc("run09_gap", 1'b0, 1'b0, 1'b0, 1'b0, f_run(9));
        cyc("tick_pause", 1'b0, 1'b0, 1'b1, 1'b1, f_pause(8));
        repeat (3) cyc("pause_tick", 1'b0, 1'b0, 1'b0, 1'b1, f_pause(8));
        cyc("pause_again", 1'b0, 1'b0, 1'b1, 1'b0, f_pause(8));
        cyc("resume", 1'b0, 1'b1, 1'b0, 1'b0, f_start(8));
        n = 8;
        for (int k = 1; k <= 8; k++) begin
            repeat (2) cyc("run8_gap", 1'b0, 1'b0, 1'b0, 1'b0, f_run(n));
            n--;
            cyc("run8_tick", 1'b0, 1'b0, 1'b0, 1'b1, (n == 0) ? f_done1() : f_run(n));
        end
        cyc("done8_hold", 1'b0, 1'b0, 1'b0, 1'b0, f_done());

        // clamping and ignored commands
        ifc.preset_i = 8'hA7;
        cyc("clamp_a7", 1'b1, 1'b0, 1'b0, 1'b0, f_idle(97));
        cyc("start97", 1'b0, 1'b1, 1'b0, 1'b0, f_start(97));
        ifc.preset_i = 8'h55;
        cyc("load_in_run", 1'b1, 1'b0, 1'b0, 1'b0, f_run(97));
        cyc("start_in_run", 1'b0, 1'b1, 1'b0, 1'b0, f_run(97));
        cyc("pause97", 1'b0, 1'b0, 1'b1, 1'b0, f_pause(97));
        ifc.preset_i = 8'hFF;
        cyc("clamp_ff", 1'b1, 1'b0, 1'b0, 1'b0, f_idle(99));
        ifc.preset_i = 8'h00;
        cyc("load00", 1'b1, 1'b0, 1'b0, 1'b0, f_idle(0));
        cyc("start_zero", 1'b0, 1'b1, 1'b0, 1'b0, f_idle(0));
        ifc.preset_i = 8'h03;
        cyc("load_beats_start", 1'b1, 1'b1, 1'b0, 1'b0, f_idle(3));

        // run 03 to done, re-arm, finish with a tick+pause at 01
        cyc("start03", 1'b0, 1'b1, 1'b0, 1'b0, f_start(3));
        cyc("run03_gap", 1'b0, 1'b0, 1'b0, 1'b0, f_run(3));
        cyc("run03_t1", 1'b0, 1'b0, 1'b0, 1'b1, f_run(2));
        cyc("run03_t2", 1'b0, 1'b0, 1'b0, 1'b1, f_run(1));
        cyc("run03_t3", 1'b0, 1'b0, 1'b0, 1'b1, f_done1());
        cyc("done03_hold", 1'b0, 1'b0, 1'b0, 1'b0, f_done());
        cyc("rearm", 1'b0, 1'b1, 1'b0, 1'b0, f_start(3));
        cyc("rearm_gap", 1'b0, 1'b0, 1'b0, 1'b0, f_run(3));
        cyc("rearm_t1", 1'b0, 1'b0, 1'b0, 1'b1, f_run(2));
        cyc("rearm_t2", 1'b0, 1'b0, 1'b0, 1'b1, f_run(1));
        cyc("done_beats_pause", 1'b0, 1'b0, 1'b1, 1'b1, f_done1());
        cyc("done_pause_ign", 1'b0, 1'b0, 1'b1, 1'b0, f_done());

        // asynchronous reset in the middle of a run at 05
        ifc.preset_i = 8'h05;
        cyc("load05", 1'b1, 1'b0, 1'b0, 1'b0, f_idle(5));
        cyc("start05", 1'b0, 1'b1, 1'b0, 1'b0, f_start(5));
        cyc("run05_gap", 1'b0, 1'b0, 1'b0, 1'b0, f_run(5));
        #2 rst = 1'b0;
        #1 check_now("async_rst", f_idle(30));
        repeat (2) cyc("rst_hold", 1'b0, 1'b1, 1'b0, 1'b1, f_idle(30));
        rst = 1'b1;
        cyc("post_rst_tick", 1'b0, 1'b0, 1'b0, 1'b1, f_idle(30));
        cyc("post_rst_start", 1'b0, 1'b1, 1'b0, 1'b0, f_start(30));
        cyc("post_rst_run", 1'b0, 1'b0, 1'b0, 1'b1, f_run(29));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Two-digit BCD seconds countdown controller that sequences the team's one-second timer block.
- Holds the timer in reset when not counting, starts it on run entry, and consumes its per-second tick to decrement a 00-99 BCD count.
- Supports load, start, pause, resume and re-arm, and flags timeout.
- Sits between debounced push-button pulses and the 7-segment display decoders in the lab top level.

Parameters:
- DEFAULT_PRESET, 8'h30, BCD count loaded at reset (tens nibble [7:4], ones nibble [3:0]).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- load_i  input  1  one-cycle pulse; load preset_i.
- preset_i  input  8  BCD preset, {tens, ones}.
- start_i  input  1  one-cycle pulse; start, resume or re-arm.
- pause_i  input  1  one-cycle pulse; pause while running.
- tick_i  input  1  one-cycle pulse from the one-second timer output.
- timer_rst_n_o  output  1  active-low reset to the one-second timer; high only in RUN.
- timer_start_o  output  1  one-cycle enable pulse to the one-second timer.
- tens_o  output  4  BCD tens digit of the current count.
- ones_o  output  4  BCD ones digit of the current count.
- busy_o  output  1  high in RUN or PAUSE.
- done_o  output  1  one-cycle pulse when the count reaches 00.
- timeout_o  output  1  level, high in DONE.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-low. All outputs are registered.
- Reset values:
  - state=IDLE; count and reload register = DEFAULT_PRESET.
  - timer_rst_n_o=0, timer_start_o=0, busy_o=0, done_o=0, timeout_o=0.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority in any cycle: load_i > start_i > pause_i.
- load_i (accepted in IDLE, PAUSE, DONE; ignored in RUN):
  - Each preset_i nibble greater than 9 clamps to 9.
  - The clamped value is written to both count and the reload register.
  - Next state is IDLE, including from PAUSE and DONE.
- IDLE:
  - start_i with count != 00: go to RUN.
  - start_i with count == 00: ignored, stays IDLE.
- Entering RUN (from IDLE, PAUSE or DONE): in the first RUN cycle, timer_rst_n_o=1 and timer_start_o=1 for exactly one cycle.
- RUN:
  - timer_rst_n_o held at 1; busy_o=1.
  - Each tick_i decrements count in BCD: ones 0 becomes ones 9 with tens-1; otherwise ones-1.
  - tick_i while count == 01: next cycle count=00, state=DONE, done_o=1 for that one cycle, timeout_o=1.
  - pause_i: go to PAUSE. timer_rst_n_o=0 from the next cycle, so the partial second is discarded.
  - tick_i coincident with pause_i: the decrement is applied, then PAUSE is entered. If that tick reaches 00, DONE takes precedence.
  - start_i in RUN is ignored.
- PAUSE:
  - count frozen; tick_i ignored; busy_o=1.
  - start_i resumes to RUN with a fresh timer_start_o pulse, giving a full second until the next tick.
  - pause_i in PAUSE is ignored.
- DONE:
  - timeout_o=1, busy_o=0, timer_rst_n_o=0, count=00.
  - start_i re-arms: count <= reload register; go to RUN if the reload value != 00, else stay in DONE.
  - load_i goes to IDLE with the new value; timeout_o clears.
- tick_i outside RUN is ignored (no count change).
- Count never wraps below 00 and never exceeds 99.
- Reset mid-run: the async assert takes effect immediately; timer_rst_n_o goes low at once, which stops the timer.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, then release -> state IDLE, tens_o=3, ones_o=0, timer_rst_n_o=0, no timer_start_o; 5 idle cycles with tick_i pulses leave count at 30.
- Preset 8'h12, load, start, then 12 ticks spaced 24 cycles apart:
  - One timer_start_o pulse on RUN entry.
  - Count steps 12, 11, 10, 09, ... 01, 00.
  - done_o pulses once on the 12th tick; timeout_o=1; timer_rst_n_o=0.
- Borrow and pause:
  - Preset 8'h10, start, 1 tick -> 09.
  - pause_i coincident with the 2nd tick -> count 08, PAUSE, timer_rst_n_o=0; further ticks leave 08.
  - start_i -> RUN, new timer_start_o pulse; 8 ticks -> 00, DONE.
- Clamp and ignore:
  - preset_i=8'hA7 with load -> count 97.
  - load_i during RUN is ignored.
  - start_i with count 00 in IDLE is ignored (busy_o stays 0).
- Re-arm: after DONE from preset 8'h03, start_i -> count 03, RUN, timer_start_o pulse; 3 ticks -> done_o again.
- Async reset mid-run: assert rst=0 between clock edges at count 05 -> outputs return to reset values immediately; count 30, IDLE.
